mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multi-cycle main control FSM for the MIPS datapath. It sequences instruction fetch, decode, execute, memory and write-back by driving the datapath mux selects, write enables and `alu_op` into `alu_ctrl`. It accounts for the one-cycle registered latency of `alu_ctrl` by giving every ALU-consuming state two phases. It sits between the instruction register opcode field, memory, the register file and `alu_ctrl`.

## Interface

- Parameters: none. Opcode and `alu_op` encodings come from the shared package.
- `clk` in 1: single rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `opcode` in 6: IR[31:26]; sampled only in DECODE phase 1.
- `zero` in 1: ALU zero flag; sampled only in BEQ_EX phase 1.
- `mem_ready` in 1: memory completion strobe for the current read or write.
- `pc_write`, `pc_write_cond` out 1: unconditional and branch PC enables.
- `i_or_d` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_read`, `mem_write` out 1: memory strobes.
- `ir_write`, `mdr_write`, `alu_out_write` out 1: datapath register enables.
- `alu_src_a` out 1: 0 = PC, 1 = rs.
- `alu_src_b` out 2: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
- `alu_op` out 3: 0 = use funct, 1 = add, 2 = and, 3 = or, 4 = sub.
- `pc_source` out 2: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `reg_dst`, `mem_to_reg`, `reg_write` out 1: register write controls.
- `state` out 4: current state code, for debug.
- `illegal` out 1: sticky flag for an unsupported opcode.

## Operation

- Moore outputs are decoded from (`state`, `phase`). The `mem_ready` gating listed below is the only exception. While `rst` is high, every output is forced to 0.
- Reset value: `state` = FETCH, `phase` = 0, `illegal` = 0. Outputs are 0 in the reset cycle; FETCH outputs apply from the first cycle after `rst` falls.
- Two-phase states are FETCH, DECODE, MEMADR, RTYPE_EX, IMM_EX and BEQ_EX.
  - Phase 0 presents `alu_op` and the sources.
  - Phase 1 holds them stable and consumes the result.
  - `phase` toggles 0→1 unconditionally, and 1→0 on leaving the state.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=1.
  - In phase 1, `ir_write`=`pc_write`=`mem_ready` and `pc_source`=0.
  - Phase 1 holds until `mem_ready`, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=1, with `alu_out_write` in phase 1 (branch target). Phase 1 dispatches on `opcode`:
  - 0x00 → RTYPE_EX
  - 0x23 or 0x2B → MEMADR
  - 0x04 → BEQ_EX
  - 0x08, 0x0C or 0x0D → IMM_EX
  - 0x02 → JUMP
  - anything else → ILLEGAL
- MEMADR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=1, `alu_out_write` in phase 1. Then → MEMRD for lw, or MEMWR for sw.
- MEMRD: `mem_read`=1, `i_or_d`=1, `mdr_write`=`mem_ready`. Holds until `mem_ready`, then → LW_WB.
- MEMWR: `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then → FETCH.
- LW_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Then → FETCH.
- RTYPE_EX: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=0, `alu_out_write` in phase 1. Then → RTYPE_WB.
- RTYPE_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Then → FETCH.
- IMM_EX: `alu_src_a`=1, `alu_src_b`=2. `alu_op` is 1 for 0x08, 2 for 0x0C and 3 for 0x0D, taken from the opcode latched in DECODE. `alu_out_write` in phase 1. Then → IMM_WB.
- IMM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Then → FETCH.
- BEQ_EX: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=4, `pc_source`=1, with `pc_write_cond`=1 in phase 1 only. Then → FETCH.
- JUMP: `pc_write`=1, `pc_source`=2, for one cycle. Then → FETCH.
- ILLEGAL: all outputs are 0 and `illegal`=1. The state is terminal until `rst`.
- The opcode is latched into an internal register in DECODE phase 1. Later states use the latched copy, never the live port.

## Timing

- Cycles per instruction with `mem_ready` tied high:
  - j: 5
  - beq: 6
  - R-type, immediate, sw: 7
  - lw: 8
- Each cycle `mem_ready` is low in FETCH phase 1, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` is ignored in every other state.
- A `mem_ready` asserted in FETCH phase 0 does not complete the fetch.
- Synchronous `rst` takes priority in any state or phase. The next cycle is FETCH phase 0, and no write enable is asserted in the reset cycle.

## Structure

- Package `mips_pkg` holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J);
  - `alu_op` codes (ALUOP_FUNCT, ALUOP_ADD, ALUOP_AND, ALUOP_OR, ALUOP_SUB);
  - the state enum typedef.
- `alu_ctrl` maps ALUOP_SUB (4) to the subtract select.
- Single module. The output decode stays in one combinational block; no sub-module is needed.

## Test plan

- add (opcode 0x00), `mem_ready`=1: 7 cycles. `ir_write` and `pc_write` in cycle 2, `alu_op`=0 in cycles 5–6, `reg_write` with `reg_dst`=1 in cycle 7, then FETCH.
- lw (0x23), `mem_ready` low for 3 MEMRD cycles: 11 cycles total. `mdr_write` is asserted only in the `mem_ready` cycle; `reg_write` with `mem_to_reg`=1 follows.
- beq (0x04) with `zero`=1 and with `zero`=0: 6 cycles each, `pc_write_cond`=1 only in cycle 6, `alu_op`=4, `pc_source`=1. Taken versus not-taken is decided in the datapath.
- j (0x02): 5 cycles, `pc_write`=1 with `pc_source`=2 in cycle 5. ori (0x0D): `alu_op`=3 in IMM_EX.
- Opcode 0x3F: ILLEGAL after DECODE, `illegal`=1 stays set for 20 cycles with all enables 0. `rst` clears it and the next cycle is FETCH.
- `rst` pulsed during MEMWR with `mem_ready` low: no `mem_write` in the reset cycle, and the next cycle is FETCH phase 0 with `mem_read`=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, alu_op
// codes, sequencer state codes and the control-word bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ALUOP_FUNCT = 3'd0;
  localparam logic [2:0] ALUOP_ADD   = 3'd1;
  localparam logic [2:0] ALUOP_AND   = 3'd2;
  localparam logic [2:0] ALUOP_OR    = 3'd3;
  localparam logic [2:0] ALUOP_SUB   = 3'd4;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWR    = 4'd4,
    ST_LW_WB    = 4'd5,
    ST_RTYPE_EX = 4'd6,
    ST_RTYPE_WB = 4'd7,
    ST_IMM_EX   = 4'd8,
    ST_IMM_WB   = 4'd9,
    ST_BEQ_EX   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_ILLEGAL  = 4'd12
  } state_t;

  // Datapath control word driven by the sequencer every cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       alu_out_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctl_t;

  // ALU operation for the immediate-arithmetic group.
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu_op = ALUOP_AND;
      OP_ORI:  imm_alu_op = ALUOP_OR;
      default: imm_alu_op = ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_sequencer.sv
// Multi-cycle main control FSM. ALU-consuming states run two phases so the
// registered alu_ctrl output is stable before the result is captured.
module mc_sequencer
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       alu_out_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [3:0] state,
  output logic       illegal
);

  state_t     st;
  logic       ph;
  logic [5:0] op_q;
  logic       ill_q;
  ctl_t       c;

  // Branch resolution (zero AND pc_write_cond) happens in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  // State/phase sequencing, opcode latch and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= ST_FETCH;
      ph    <= 1'b0;
      op_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      case (st)
        ST_FETCH: begin
          if (!ph) ph <= 1'b1;
          else if (mem_ready) begin
            st <= ST_DECODE;
            ph <= 1'b0;
          end
        end
        ST_DECODE: begin
          if (!ph) ph <= 1'b1;
          else begin
            ph   <= 1'b0;
            op_q <= opcode;
            case (opcode)
              OP_RTYPE:                st <= ST_RTYPE_EX;
              OP_LW, OP_SW:            st <= ST_MEMADR;
              OP_BEQ:                  st <= ST_BEQ_EX;
              OP_ADDI, OP_ANDI, OP_ORI: st <= ST_IMM_EX;
              OP_J:                    st <= ST_JUMP;
              default: begin
                st    <= ST_ILLEGAL;
                ill_q <= 1'b1;
              end
            endcase
          end
        end
        ST_MEMADR: begin
          if (!ph) ph <= 1'b1;
          else begin
            ph <= 1'b0;
            if (op_q == OP_LW) st <= ST_MEMRD;
            else               st <= ST_MEMWR;
          end
        end
        ST_MEMRD: if (mem_ready) st <= ST_LW_WB;
        ST_MEMWR: if (mem_ready) st <= ST_FETCH;
        ST_RTYPE_EX: begin
          if (!ph) ph <= 1'b1;
          else begin
            ph <= 1'b0;
            st <= ST_RTYPE_WB;
          end
        end
        ST_IMM_EX: begin
          if (!ph) ph <= 1'b1;
          else begin
            ph <= 1'b0;
            st <= ST_IMM_WB;
          end
        end
        ST_BEQ_EX: begin
          if (!ph) ph <= 1'b1;
          else begin
            ph <= 1'b0;
            st <= ST_FETCH;
          end
        end
        ST_LW_WB, ST_RTYPE_WB, ST_IMM_WB, ST_JUMP: st <= ST_FETCH;
        ST_ILLEGAL: st <= ST_ILLEGAL;
        default: begin
          st <= ST_FETCH;
          ph <= 1'b0;
        end
      endcase
    end
  end

  // Moore decode of (state, phase); mem_ready gates only the capture enables.
  always_comb begin
    c = '0;
    if (!rst) begin
      case (st)
        ST_FETCH: begin
          c.mem_read  = 1'b1;
          c.alu_src_b = 2'd1;
          c.alu_op    = ALUOP_ADD;
          if (ph) begin
            c.ir_write = mem_ready;
            c.pc_write = mem_ready;
          end
        end
        ST_DECODE: begin
          c.alu_src_b     = 2'd3;
          c.alu_op        = ALUOP_ADD;
          c.alu_out_write = ph;
        end
        ST_MEMADR: begin
          c.alu_src_a     = 1'b1;
          c.alu_src_b     = 2'd2;
          c.alu_op        = ALUOP_ADD;
          c.alu_out_write = ph;
        end
        ST_MEMRD: begin
          c.mem_read  = 1'b1;
          c.i_or_d    = 1'b1;
          c.mdr_write = mem_ready;
        end
        ST_MEMWR: begin
          c.mem_write = 1'b1;
          c.i_or_d    = 1'b1;
        end
        ST_LW_WB: begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
        end
        ST_RTYPE_EX: begin
          c.alu_src_a     = 1'b1;
          c.alu_op        = ALUOP_FUNCT;
          c.alu_out_write = ph;
        end
        ST_RTYPE_WB: begin
          c.reg_write = 1'b1;
          c.reg_dst   = 1'b1;
        end
        ST_IMM_EX: begin
          c.alu_src_a     = 1'b1;
          c.alu_src_b     = 2'd2;
          c.alu_op        = imm_alu_op(op_q);
          c.alu_out_write = ph;
        end
        ST_IMM_WB: c.reg_write = 1'b1;
        ST_BEQ_EX: begin
          c.alu_src_a     = 1'b1;
          c.alu_op        = ALUOP_SUB;
          c.pc_source     = 2'd1;
          c.pc_write_cond = ph;
        end
        ST_JUMP: begin
          c.pc_write  = 1'b1;
          c.pc_source = 2'd2;
        end
        default: c = '0;
      endcase
    end
  end

  assign pc_write      = c.pc_write;
  assign pc_write_cond = c.pc_write_cond;
  assign i_or_d        = c.i_or_d;
  assign mem_read      = c.mem_read;
  assign mem_write     = c.mem_write;
  assign ir_write      = c.ir_write;
  assign mdr_write     = c.mdr_write;
  assign alu_out_write = c.alu_out_write;
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign alu_op        = c.alu_op;
  assign pc_source     = c.pc_source;
  assign reg_dst       = c.reg_dst;
  assign mem_to_reg    = c.mem_to_reg;
  assign reg_write     = c.reg_write;
  assign state         = rst ? 4'd0 : st;
  assign illegal       = ill_q & ~rst;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: each instruction expands into a list of expected
// per-cycle control words; stall steps repeat while mem_ready is low.
module tb_mc_sequencer;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       ir_write, mdr_write, alu_out_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic       reg_dst, mem_to_reg, reg_write, illegal;
  logic [3:0] state;

  mc_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mdr_write(mdr_write), .alu_out_write(alu_out_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pw, pwc, iord, mrd, mwr, irw, mdrw, aow, asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic [1:0] psrc;
    logic       rdst, m2r, rw;
    logic [3:0] st;
    logic       ill;
  } exp_t;

  // wk: 0 = plain step, 1 = fetch stall, 2 = read stall, 3 = write stall, 4 = terminal
  typedef struct {
    exp_t c;
    int   wk;
    bit   dec1;
  } step_t;

  exp_t obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mdr_write, alu_out_write, alu_src_a, alu_src_b, alu_op, pc_source,
                reg_dst, mem_to_reg, reg_write, state, illegal};

  step_t      q[$];
  logic [5:0] cur_op;
  int         mr_mode;   // 0: mem_ready high, 1: random
  int         mem_low;   // forced-low cycles in MEMRD/MEMWR
  int         zero_val;  // -1: random
  int         nasrt = 0;
  int         nfail = 0;

  localparam logic [5:0] OPS [9] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
                                      OP_ANDI, OP_ORI, OP_J, OP_RTYPE};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    nasrt++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, o, e, $time);
    end
  endtask

  function automatic exp_t base(input state_t s);
    exp_t c;
    c = '0;
    c.st = s;
    return c;
  endfunction

  task automatic push(input exp_t c, input int wk = 0, input bit d = 0);
    step_t s;
    s.c = c; s.wk = wk; s.dec1 = d;
    q.push_back(s);
  endtask

  // Expected per-cycle control words of one instruction.
  task automatic build(input logic [5:0] op);
    exp_t c;
    c = base(ST_FETCH); c.mrd = 1; c.asb = 1; c.aop = 1;
    push(c); push(c, 1);
    c = base(ST_DECODE); c.asb = 3; c.aop = 1;
    push(c); c.aow = 1; push(c, 0, 1);
    case (op)
      OP_RTYPE: begin
        c = base(ST_RTYPE_EX); c.asa = 1; c.aop = 0;
        push(c); c.aow = 1; push(c);
        c = base(ST_RTYPE_WB); c.rw = 1; c.rdst = 1; push(c);
      end
      OP_LW, OP_SW: begin
        c = base(ST_MEMADR); c.asa = 1; c.asb = 2; c.aop = 1;
        push(c); c.aow = 1; push(c);
        if (op == OP_LW) begin
          c = base(ST_MEMRD); c.mrd = 1; c.iord = 1; push(c, 2);
          c = base(ST_LW_WB); c.rw = 1; c.m2r = 1; push(c);
        end else begin
          c = base(ST_MEMWR); c.mwr = 1; c.iord = 1; push(c, 3);
        end
      end
      OP_BEQ: begin
        c = base(ST_BEQ_EX); c.asa = 1; c.aop = 4; c.psrc = 1;
        push(c); c.pwc = 1; push(c);
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        c = base(ST_IMM_EX); c.asa = 1; c.asb = 2;
        c.aop = (op == OP_ADDI) ? 3'd1 : (op == OP_ANDI) ? 3'd2 : 3'd3;
        push(c); c.aow = 1; push(c);
        c = base(ST_IMM_WB); c.rw = 1; push(c);
      end
      OP_J: begin
        c = base(ST_JUMP); c.pw = 1; c.psrc = 2; push(c);
      end
      default: begin
        c = base(ST_ILLEGAL); c.ill = 1; push(c, 4);
      end
    endcase
  endtask

  // One clock: drive inputs, check at negedge, advance the model after posedge.
  task automatic run_cycle();
    step_t s;
    exp_t  e;
    s = q[0];
    if (mr_mode == 0) mem_ready = 1'b1;
    else              mem_ready = ($urandom_range(0, 9) < 7);
    if ((s.wk == 2 || s.wk == 3) && mem_low > 0) begin
      mem_ready = 1'b0;
      mem_low--;
    end
    opcode = s.dec1 ? cur_op : 6'($urandom);
    zero   = (zero_val < 0) ? 1'($urandom) : 1'(zero_val);
    @(negedge clk);
    e = s.c;
    if (s.wk == 1 && mem_ready) begin e.irw = 1; e.pw = 1; end
    if (s.wk == 2 && mem_ready) e.mdrw = 1;
    chk($sformatf("ctl st=%0d wk=%0d mr=%0b", s.c.st, s.wk, mem_ready), 32'(obs), 32'(e));
    @(posedge clk); #1;
    if (s.wk != 4 && !((s.wk >= 1 && s.wk <= 3) && !mem_ready)) void'(q.pop_front());
  endtask

  task automatic run_instr(input logic [5:0] op, input int exp_cyc);
    int n;
    cur_op = op;
    q.delete();
    build(op);
    n = 0;
    while (q.size() > 0 && n < 300) begin
      run_cycle();
      n++;
    end
    if (q.size() > 0) chk($sformatf("timeout op=%h", op), 32'(q.size()), 32'd0);
    if (exp_cyc >= 0) chk($sformatf("cycles op=%h", op), 32'(n), 32'(exp_cyc));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'($urandom);
    @(negedge clk);
    chk("reset_outputs", 32'(obs), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
  endtask

  initial begin
    int n;
    mr_mode = 0; mem_low = 0; zero_val = -1; cur_op = '0;
    @(posedge clk); #1;
    do_reset();
    do_reset();

    // Directed instructions, mem_ready high except where stated.
    run_instr(OP_RTYPE, 7);
    mem_low = 3;
    run_instr(OP_LW, 11);
    mem_low = 0;
    zero_val = 1; run_instr(OP_BEQ, 6);
    zero_val = 0; run_instr(OP_BEQ, 6);
    zero_val = -1;
    run_instr(OP_J, 5);
    run_instr(OP_ORI, 7);
    run_instr(OP_ANDI, 7);
    run_instr(OP_ADDI, 7);
    run_instr(OP_SW, 7);
    run_instr(OP_LW, 8);

    // Random instruction stream with random memory latency.
    mr_mode = 1;
    for (int i = 0; i < 150; i++) run_instr(OPS[$urandom_range(0, 8)], -1);

    // Unsupported opcode: terminal ILLEGAL until reset.
    cur_op = 6'h3F;
    q.delete();
    build(cur_op);
    n = 0;
    while (q[0].wk != 4 && n < 300) begin run_cycle(); n++; end
    chk("reach_illegal", 32'(q[0].wk), 32'd4);
    for (int i = 0; i < 20; i++) run_cycle();
    do_reset();
    mr_mode = 0;
    run_instr(OP_RTYPE, 7);

    // Reset while a store is stalled in MEMWR.
    cur_op = OP_SW;
    q.delete();
    build(OP_SW);
    mem_low = 10;
    n = 0;
    while (q[0].wk != 3 && n < 300) begin run_cycle(); n++; end
    chk("reach_memwr", 32'(q[0].wk), 32'd3);
    run_cycle();
    run_cycle();
    chk("memwr_stalled", 32'(mem_write), 32'd1);
    mem_low = 0;
    do_reset();
    run_instr(OP_J, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
